// File: rtl/distribuidor_if.sv
// Bus bundle for the 1-to-8 distributor: write-side controls plus the eight holding registers.
// Optional VALIDOS vector is present only when DISTRIB_VALIDOS_EN is defined.
interface distribuidor_if;
  logic [3:0]       dado;
  logic [2:0]       sel;
  logic             we;
  logic             seq;
  logic             limpa;
  logic [7:0][3:0]  s;
  logic [2:0]       ultimo;
  logic             ocupado;
  logic             cheio;
`ifdef DISTRIB_VALIDOS_EN
  logic [7:0]       validos;
`endif

  modport master (
    output dado, sel, we, seq, limpa,
`ifdef DISTRIB_VALIDOS_EN
    input  validos,
`endif
    input  s, ultimo, ocupado, cheio
  );

  modport slave (
    input  dado, sel, we, seq, limpa,
`ifdef DISTRIB_VALIDOS_EN
    output validos,
`endif
    output s, ultimo, ocupado, cheio
  );
endinterface

// File: rtl/distribuidor.sv
// Registered 1-to-8 distributor of 4-bit words with random and sequential fill modes.
// Define DISTRIB_VALIDOS_EN to add the per-slot VALIDOS written flags.
module distribuidor (
  input  logic            CLK,
  input  logic            RST_N,
  distribuidor_if.slave   bus
);

  typedef enum logic {
    LIVRE      = 1'b0,
    SEQUENCIAL = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [7:0][3:0]  slots_q, slots_d;
  logic [2:0]       ultimo_q, ultimo_d;
  logic             cheio_q, cheio_d;
`ifdef DISTRIB_VALIDOS_EN
  logic [7:0]       validos_q, validos_d;
`endif

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    state_d   = state_q;
    ptr_d     = ptr_q;
    slots_d   = slots_q;
    ultimo_d  = ultimo_q;
    cheio_d   = 1'b0;
`ifdef DISTRIB_VALIDOS_EN
    validos_d = validos_q;
`endif

    if (bus.limpa) begin
      // Clear wins over any concurrent write or fill request.
      state_d   = LIVRE;
      ptr_d     = 3'd0;
      slots_d   = '0;
      ultimo_d  = 3'd0;
`ifdef DISTRIB_VALIDOS_EN
      validos_d = 8'h00;
`endif
    end else begin
      case (state_q)
        LIVRE: begin
          if (bus.we) begin
            slots_d[bus.sel] = bus.dado;
            ultimo_d         = bus.sel;
`ifdef DISTRIB_VALIDOS_EN
            validos_d[bus.sel] = 1'b1;
`endif
          end
          if (bus.seq) begin
            state_d = SEQUENCIAL;
            ptr_d   = 3'd0;
          end
        end
        SEQUENCIAL: begin
          if (bus.we) begin
            slots_d[ptr_q] = bus.dado;
            ultimo_d       = ptr_q;
            ptr_d          = ptr_q + 3'd1;
`ifdef DISTRIB_VALIDOS_EN
            validos_d[ptr_q] = 1'b1;
`endif
            if (ptr_q == 3'd7) begin
              state_d = LIVRE;
              cheio_d = 1'b1;
            end
          end
        end
        default: state_d = LIVRE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= LIVRE;
      ptr_q     <= 3'd0;
      // NOTE: the slot file is reset because its contents are directly visible downstream.
      slots_q   <= '0;
      ultimo_q  <= 3'd0;
      cheio_q   <= 1'b0;
`ifdef DISTRIB_VALIDOS_EN
      validos_q <= 8'h00;
`endif
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values and updates together.
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      slots_q   <= slots_d;
      ultimo_q  <= ultimo_d;
      cheio_q   <= cheio_d;
`ifdef DISTRIB_VALIDOS_EN
      validos_q <= validos_d;
`endif
    end
  end

  assign bus.s       = slots_q;
  assign bus.ultimo  = ultimo_q;
  assign bus.ocupado = (state_q == SEQUENCIAL);
  assign bus.cheio   = cheio_q;
`ifdef DISTRIB_VALIDOS_EN
  assign bus.validos = validos_q;
`endif

endmodule

// File: tb/tb_distribuidor.sv
// Directed bench for distribuidor: random writes, sequential fill, stall, clear, async reset, back-to-back.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_distribuidor;

  logic CLK;
  logic RST_N;
  int   n_cmp;
  int   n_err;

  distribuidor_if bus ();

  distribuidor dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.dado  = 4'h0;
    bus.sel   = 3'd0;
    bus.we    = 1'b0;
    bus.seq   = 1'b0;
    bus.limpa = 1'b0;
  endtask

  task automatic chk_s(input string name, input logic [31:0] exp);
    n_cmp++;
    if (bus.s !== exp) begin
      n_err++;
      $display("FAIL %s: slots got %h want %h", name, bus.s, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b", name, got, exp);
    end
  endtask

  task automatic chk_ult(input string name, input logic [2:0] exp);
    n_cmp++;
    if (bus.ultimo !== exp) begin
      n_err++;
      $display("FAIL %s: ultimo got %0d want %0d", name, bus.ultimo, exp);
    end
  endtask

  task automatic do_clear();
    bus.limpa = 1'b1;
    tick();
    idle();
  endtask

  task automatic pulse_seq();
    bus.seq = 1'b1;
    tick();
    bus.seq = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    RST_N = 1'b0;
    #3;
    chk_s("reset_slots", 32'h0);
    chk_ult("reset_ultimo", 3'd0);
    chk_bit("reset_ocupado", bus.ocupado, 1'b0);
    chk_bit("reset_cheio", bus.cheio, 1'b0);
    @(negedge CLK);
    RST_N = 1'b1;
    tick();
    chk_s("post_reset_slots", 32'h0);
  endtask

  task automatic test_random_writes();
    bus.we = 1'b1; bus.sel = 3'd5; bus.dado = 4'hA;
    tick();
    chk_s("rand_first", 32'h00A0_0000);
    chk_ult("rand_first_ultimo", 3'd5);
    bus.sel = 3'd0; bus.dado = 4'h3;
    tick();
    idle();
    chk_s("rand_second", 32'h00A0_0003);
    chk_ult("rand_second_ultimo", 3'd0);
    chk_bit("rand_ocupado", bus.ocupado, 1'b0);
    tick();
    chk_s("rand_hold", 32'h00A0_0003);
  endtask

  task automatic test_sequential_fill();
    pulse_seq();
    chk_bit("fill_ocupado_start", bus.ocupado, 1'b1);
    chk_s("fill_no_write_on_seq", 32'h00A0_0003);
    for (int i = 0; i < 8; i++) begin
      bus.we = 1'b1; bus.dado = 4'(i + 1);
      tick();
      chk_ult("fill_ultimo", 3'(i));
      chk_bit("fill_ocupado", bus.ocupado, (i < 7));
      chk_bit("fill_cheio", bus.cheio, (i == 7));
    end
    idle();
    chk_s("fill_contents", 32'h8765_4321);
    tick();
    chk_bit("fill_cheio_one_cycle", bus.cheio, 1'b0);
    chk_bit("fill_ocupado_end", bus.ocupado, 1'b0);
  endtask

  task automatic test_stall_ignore();
    logic [3:0] tail [5] = '{4'hC, 4'hD, 4'hE, 4'hF, 4'h1};
    do_clear();
    pulse_seq();
    bus.we = 1'b1;
    bus.dado = 4'h9; tick();
    bus.dado = 4'hA; tick();
    bus.dado = 4'hB; tick();
    bus.we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.seq = ~bus.seq; bus.sel = 3'(i + 4); bus.dado = 4'h5;
      tick();
      chk_s("stall_no_write", 32'h0000_0BA9);
      chk_ult("stall_ultimo", 3'd2);
      chk_bit("stall_ocupado", bus.ocupado, 1'b1);
    end
    bus.seq = 1'b0;
    bus.we  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.dado = tail[i];
      tick();
    end
    idle();
    chk_s("stall_contents", 32'h1FED_CBA9);
    chk_ult("stall_ultimo_end", 3'd7);
    chk_bit("stall_cheio", bus.cheio, 1'b1);
    chk_bit("stall_ocupado_end", bus.ocupado, 1'b0);
    tick();
  endtask

  task automatic test_clear_priority();
    pulse_seq();
    bus.we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.dado = 4'(i + 2);
      tick();
    end
    chk_ult("clr_ptr4_ultimo", 3'd3);
    bus.limpa = 1'b1; bus.dado = 4'hF;
    tick();
    idle();
    chk_s("clr_slots", 32'h0);
    chk_ult("clr_ultimo", 3'd0);
    chk_bit("clr_ocupado", bus.ocupado, 1'b0);
    chk_bit("clr_cheio", bus.cheio, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_bit("clr_cheio_quiet", bus.cheio, 1'b0);
    end
    pulse_seq();
    bus.we = 1'b1; bus.dado = 4'h7;
    tick();
    bus.we = 1'b0;
    chk_s("clr_restart_slot0", 32'h0000_0007);
    chk_ult("clr_restart_ultimo", 3'd0);
  endtask

  task automatic test_async_reset();
    bus.we = 1'b1;
    bus.dado = 4'h4; tick();
    bus.dado = 4'h6; tick();
    chk_s("async_pre", 32'h0000_0647);
    #3;
    RST_N = 1'b0;
    #1;
    chk_s("async_slots", 32'h0);
    chk_ult("async_ultimo", 3'd0);
    chk_bit("async_ocupado", bus.ocupado, 1'b0);
    chk_bit("async_cheio", bus.cheio, 1'b0);
    idle();
    #1;
    RST_N = 1'b1;
    tick();
    chk_s("async_after_release", 32'h0);
    pulse_seq();
    bus.we = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.dado = 4'(i + 5);
      tick();
      if (i == 0) chk_s("async_fresh_slot0", 32'h0000_0005);
    end
    idle();
    chk_s("async_refill", 32'hCBA9_8765);
    chk_bit("async_refill_cheio", bus.cheio, 1'b1);
    tick();
  endtask

  task automatic test_back_to_back();
    do_clear();
    pulse_seq();
    bus.we = 1'b1; bus.dado = 4'h1;
    for (int i = 0; i < 8; i++) tick();
    chk_bit("b2b_cheio", bus.cheio, 1'b1);
    chk_s("b2b_filled", 32'h1111_1111);
    bus.seq = 1'b1; bus.we = 1'b1; bus.sel = 3'd3; bus.dado = 4'hE;
    tick();
    bus.seq = 1'b0;
    chk_bit("b2b_ocupado", bus.ocupado, 1'b1);
    chk_bit("b2b_cheio_drop", bus.cheio, 1'b0);
    chk_s("b2b_random_write", 32'h1111_E111);
    chk_ult("b2b_random_ultimo", 3'd3);
    bus.dado = 4'h2;
    tick();
    chk_s("b2b_seq_slot0", 32'h1111_E112);
    chk_ult("b2b_seq_ultimo", 3'd0);
    do_clear();
  endtask

`ifdef DISTRIB_VALIDOS_EN
  task automatic test_validos();
    do_clear();
    n_cmp++;
    if (bus.validos !== 8'h00) begin
      n_err++;
      $display("FAIL validos_clear0: got %h want 00", bus.validos);
    end
    bus.we = 1'b1; bus.sel = 3'd2; bus.dado = 4'h1; tick();
    bus.sel = 3'd6; tick();
    idle();
    n_cmp++;
    if (bus.validos !== 8'h44) begin
      n_err++;
      $display("FAIL validos_set: got %h want 44", bus.validos);
    end
    do_clear();
    n_cmp++;
    if (bus.validos !== 8'h00) begin
      n_err++;
      $display("FAIL validos_limpa: got %h want 00", bus.validos);
    end
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_err = 0;
    RST_N = 1'b0;
    idle();
    test_reset();
    test_random_writes();
    test_sequential_fill();
    test_stall_ignore();
    test_clear_priority();
    test_async_reset();
    test_back_to_back();
`ifdef DISTRIB_VALIDOS_EN
    test_validos();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
